hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; sits beside id_stage.
- Consumes decoded fields of the instruction in ID (rs, rt, destination, class) and keeps shadow copies of the EX/MEM/WB destinations.
- Generates PC/IF-ID stall, ID-EX bubble, IF-ID flush and EX operand forwarding selects.
- Also sequences the multi-cycle multiply/divide unit (MDU) and counts stall cycles.

Parameters:
MDU_LATENCY, 4, cycles the MDU occupies per operation (legal 2..15)
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
id_valid  in  1  ID holds a real instruction
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  5  ID destination register (rd for R-type, rt for I-type)
id_wr_en  in  1  ID instruction writes the register file
id_is_load  in  1  ID instruction is lw
id_is_mdu  in  1  ID instruction is mult/div
ex_branch_taken  in  1  branch in EX resolved taken
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
idex_bubble  out  1  load NOP into ID/EX
ifid_flush  out  1  clear IF/ID to NOP
fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 MEM result, 10 WB result
fwd_b_sel  out  2  EX operand B source, same encoding
mdu_busy  out  1  MDU operation in progress
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset=0, async):
  - shadow EX/MEM/WB valid bits cleared; MDU counter = 0; stall_count = 0.
  - All outputs 0; fwd selects 00.
- Shadow pipeline:
  - ex_sh holds {valid, dest, wr_en, is_load, rs, rt}; mem_sh and wb_sh hold {valid, dest, wr_en}.
  - Each clock: wb_sh <= mem_sh; mem_sh <= ex_sh (minus rs/rt).
  - ex_sh <= ID fields with valid=id_valid, except when stall or flush, when ex_sh.valid <= 0.
- Load-use hazard (combinational), lu = all of:
  - id_valid, ex_sh.valid, ex_sh.is_load, ex_sh.wr_en;
  - ex_sh.dest != 0;
  - (id_uses_rs && id_rs == ex_sh.dest) || (id_uses_rt && id_rt == ex_sh.dest).
- MDU sequencing:
  - When an id_is_mdu instruction issues (no stall, no flush), counter <= MDU_LATENCY-1.
  - Otherwise the counter decrements when nonzero; mdu_busy = (counter != 0).
  - md = id_valid && id_is_mdu && mdu_busy.
- Stall:
  - stall = (lu || md) && !ex_branch_taken.
  - pc_stall = ifid_stall = idex_bubble = stall.
- Flush:
  - ex_branch_taken gives ifid_flush=1 and idex_bubble=1, with pc_stall=0 and ifid_stall=0.
  - Flush beats stall in the same cycle.
  - The flushed ID instruction never issues, so an MDU op in ID is not started; a running MDU counter keeps counting.
- Forwarding (combinational from ex_sh/mem_sh/wb_sh, for the instruction in EX):
  - fwd_a_sel=01 if mem_sh.valid && mem_sh.wr_en && mem_sh.dest != 0 && mem_sh.dest == ex_sh.rs.
  - Else fwd_a_sel=10 on the same test against wb_sh.
  - Else 00.
  - fwd_b_sel: same rules using ex_sh.rt.
  - MEM has priority over WB. Register $0 is never forwarded. Selects are 00 when ex_sh.valid=0.
- stall_count:
  - Increments on each clock where stall=1; saturates at all-ones and never wraps.
  - Flush cycles are not counted.
- Latency:
  - Stall/flush/forward outputs are same-cycle combinational.
  - Shadow state updates on the next rising edge.

Test Plan:
- Load-use: lw $8 in EX, ID add $9,$8,$7 (rs=8, uses_rs=1) -> pc_stall=ifid_stall=idex_bubble=1 for exactly 1 cycle; stall_count=1; when the add reaches EX, fwd_a_sel=10, fwd_b_sel=00.
- Back-to-back ALU: addi $9,$8,5 followed by add $10,$9,$7 -> no stall; add in EX sees fwd_a_sel=01. With one unrelated instruction between them -> fwd_a_sel=10.
- $0 destination: addi $0,$8,5 then add $10,$0,$7 -> fwd_a_sel=00, and no stall even if the first is lw $0.
- Flush priority: ex_branch_taken=1 in the same cycle as a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_stall=0; stall_count unchanged; the next ex_sh is a bubble.
- MDU (MDU_LATENCY=4): mult followed immediately by div -> mdu_busy=1 for 3 cycles; div stalled 3 cycles then issues; stall_count=3.
- Reset mid-operation: assert reset=0 asynchronously while mdu_busy=1 and ex_sh is valid -> all outputs 0 immediately, before any clock edge; after release, a mult-class ID instruction issues with no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core. It detects load-use and MDU-busy
// stalls, branch flushes and EX forwarding, and counts the cycles lost to stalls.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             id_is_mdu,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wr_en;
        logic       is_load;
        logic [4:0] rs;
        logic [4:0] rt;
    } ex_sh_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       wr_en;
    } wr_sh_t;

    localparam logic [3:0] MDU_INIT = 4'(MDU_LATENCY - 1);

    ex_sh_t     ex_sh;
    wr_sh_t     mem_sh;
    wr_sh_t     wb_sh;
    logic [3:0] mdu_cnt;

    logic br;
    logic lu;
    logic md;
    logic stall;
    logic issue;

    function automatic logic hits(input wr_sh_t sh, input logic [4:0] src);
        return sh.valid && sh.wr_en && (sh.dest != 5'd0) && (sh.dest == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic ex_valid,
                                           input wr_sh_t m, input wr_sh_t w);
        if (!ex_valid)         return 2'b00;
        else if (hits(m, src)) return 2'b01;
        else if (hits(w, src)) return 2'b10;
        else                   return 2'b00;
    endfunction

    // A branch only counts once reset is released, so every output is 0 in reset.
    assign br       = ex_branch_taken && reset;
    assign mdu_busy = (mdu_cnt != 4'd0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        lu = 1'b0;
        if (id_valid && ex_sh.valid && ex_sh.is_load && ex_sh.wr_en && (ex_sh.dest != 5'd0))
            lu = (id_uses_rs && (id_rs == ex_sh.dest)) || (id_uses_rt && (id_rt == ex_sh.dest));
    end

    assign md    = id_valid && id_is_mdu && mdu_busy;
    assign stall = (lu || md) && !br;
    assign issue = id_valid && !stall && !br;

    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall || br;
    assign ifid_flush  = br;
    assign fwd_a_sel   = fwd_sel(ex_sh.rs, ex_sh.valid, mem_sh, wb_sh);
    assign fwd_b_sel   = fwd_sel(ex_sh.rt, ex_sh.valid, mem_sh, wb_sh);

    // NOTE: state registers use non-blocking assignments so all shadows advance together on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_sh       <= '0;
            mem_sh      <= '0;
            wb_sh       <= '0;
            mdu_cnt     <= 4'd0;
            stall_count <= '0;
        end else begin
            wb_sh  <= mem_sh;
            mem_sh <= '{valid: ex_sh.valid, dest: ex_sh.dest, wr_en: ex_sh.wr_en};
            ex_sh  <= '{valid: issue, dest: id_dest, wr_en: id_wr_en, is_load: id_is_load,
                        rs: id_rs, rt: id_rt};

            // A flushed or stalled MDU op never starts; a running one keeps counting.
            if (issue && id_is_mdu)
                mdu_cnt <= MDU_INIT;
            else if (mdu_cnt != 4'd0)
                mdu_cnt <= mdu_cnt - 4'd1;

            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios followed by random instruction
// streams, all compared against an in-order pipeline model kept as a queue.
module tb_hazard_ctrl;

    localparam int LAT   = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        bit       valid;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       uses_rs;
        bit       uses_rt;
        bit [4:0] dest;
        bit       wr_en;
        bit       is_load;
        bit       is_mdu;
    } instr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic [4:0]    id_rs = '0, id_rt = '0, id_dest = '0;
    logic          id_wr_en = 1'b0, id_is_load = 1'b0, id_is_mdu = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          pc_stall, ifid_stall, idex_bubble, ifid_flush, mdu_busy;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_count;

    hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
        .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mdu_busy(mdu_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    instr_t pipe[$];      // [0]=EX, [1]=MEM, [2]=WB
    int     cycle = 0;
    int     mdu_done = 0; // first cycle in which the MDU is free again
    int     cnt_m = 0;
    instr_t cur;
    bit     cur_br;
    bit     e_stall;
    int     saved;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t bubble();
        instr_t i = '{default: 0};
        return i;
    endfunction

    function automatic instr_t alu(input int rs, input int rt, input int rd, input bit use_rt);
        instr_t i = '{default: 0};
        i.valid = 1; i.rs = 5'(rs); i.rt = 5'(rt); i.uses_rs = 1; i.uses_rt = use_rt;
        i.dest = 5'(rd); i.wr_en = 1;
        return i;
    endfunction

    function automatic instr_t lw(input int base, input int rd);
        instr_t i = alu(base, rd, rd, 0);
        i.is_load = 1;
        return i;
    endfunction

    function automatic instr_t mdu(input int rs, input int rt);
        instr_t i = alu(rs, rt, 0, 1);
        i.wr_en = 0; i.is_mdu = 1;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i = '{default: 0};
        i.valid   = ($urandom_range(0, 9) != 0);
        i.rs      = 5'($urandom_range(0, 3));
        i.rt      = 5'($urandom_range(0, 3));
        i.uses_rs = 1'($urandom_range(0, 1));
        i.uses_rt = 1'($urandom_range(0, 1));
        i.dest    = 5'($urandom_range(0, 3));
        i.wr_en   = ($urandom_range(0, 3) != 0);
        i.is_load = ($urandom_range(0, 2) == 0);
        i.is_mdu  = ($urandom_range(0, 6) == 0);
        return i;
    endfunction

    function automatic bit writes(input instr_t s, input bit [4:0] r);
        return s.valid && s.wr_en && s.dest != 0 && s.dest == r;
    endfunction

    function automatic logic [1:0] exp_fwd(input bit [4:0] r);
        if (!pipe[0].valid)       return 2'b00;
        if (writes(pipe[1], r))   return 2'b01;
        if (writes(pipe[2], r))   return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        pipe = {bubble(), bubble(), bubble()};
        mdu_done = 0;
        cnt_m = 0;
    endtask

    task automatic apply(input instr_t i, input bit br);
        bit lu, busy;
        id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_uses_rs = i.uses_rs;
        id_uses_rt = i.uses_rt; id_dest = i.dest; id_wr_en = i.wr_en;
        id_is_load = i.is_load; id_is_mdu = i.is_mdu; ex_branch_taken = br;
        cur = i; cur_br = br;
        #1;
        lu = i.valid && writes(pipe[0], pipe[0].dest) && pipe[0].is_load &&
             ((i.uses_rs && i.rs == pipe[0].dest) || (i.uses_rt && i.rt == pipe[0].dest));
        busy = cycle < mdu_done;
        e_stall = (lu || (i.valid && i.is_mdu && busy)) && !br;
        chk("pc_stall",    16'(pc_stall),    16'(e_stall));
        chk("ifid_stall",  16'(ifid_stall),  16'(e_stall));
        chk("idex_bubble", 16'(idex_bubble), 16'(e_stall || br));
        chk("ifid_flush",  16'(ifid_flush),  16'(br));
        chk("fwd_a_sel",   16'(fwd_a_sel),   16'(exp_fwd(pipe[0].rs)));
        chk("fwd_b_sel",   16'(fwd_b_sel),   16'(exp_fwd(pipe[0].rt)));
        chk("mdu_busy",    16'(mdu_busy),    16'(busy));
        chk("stall_count", 16'(stall_count), 16'(cnt_m));
    endtask

    task automatic tick();
        bit issue;
        @(posedge clk);
        issue = cur.valid && !e_stall && !cur_br;
        if (e_stall && cnt_m < CMAX) cnt_m++;
        if (issue && cur.is_mdu) mdu_done = cycle + LAT;
        pipe.push_front(issue ? cur : bubble());
        void'(pipe.pop_back());
        cycle++;
        @(negedge clk);
    endtask

    task automatic step(input instr_t i, input bit br);
        apply(i, br);
        tick();
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_pc"},   16'(pc_stall),    16'd0);
        chk({tag, "_ifid"}, 16'(ifid_stall),  16'd0);
        chk({tag, "_bub"},  16'(idex_bubble), 16'd0);
        chk({tag, "_fl"},   16'(ifid_flush),  16'd0);
        chk({tag, "_fa"},   16'(fwd_a_sel),   16'd0);
        chk({tag, "_fb"},   16'(fwd_b_sel),   16'd0);
        chk({tag, "_busy"}, 16'(mdu_busy),    16'd0);
        chk({tag, "_cnt"},  16'(stall_count), 16'd0);
    endtask

    initial begin
        model_reset();
        #12;
        all_zero("rst");
        @(negedge clk);
        reset = 1'b1;

        // Load-use: lw $8 then add $9,$8,$7.
        step(lw(1, 8), 0);
        apply(alu(8, 7, 9, 1), 0);
        chk("lu_stall", 16'(pc_stall), 16'd1);
        tick();
        chk("lu_cnt", 16'(stall_count), 16'd1);
        apply(alu(8, 7, 9, 1), 0);
        chk("lu_release", 16'(pc_stall), 16'd0);
        tick();
        apply(bubble(), 0);
        chk("lu_fwd_a", 16'(fwd_a_sel), 16'd2);
        chk("lu_fwd_b", 16'(fwd_b_sel), 16'd0);
        tick();

        // Back-to-back ALU, then with one unrelated instruction between.
        step(alu(8, 0, 9, 0), 0);
        apply(alu(9, 7, 10, 1), 0);
        chk("b2b_nostall", 16'(pc_stall), 16'd0);
        tick();
        apply(bubble(), 0);
        chk("b2b_fwd_mem", 16'(fwd_a_sel), 16'd1);
        tick();
        step(alu(8, 0, 9, 0), 0);
        step(alu(3, 4, 5, 1), 0);
        step(alu(9, 7, 10, 1), 0);
        apply(bubble(), 0);
        chk("gap_fwd_wb", 16'(fwd_a_sel), 16'd2);
        tick();

        // $0 destination is never a hazard nor forwarded.
        step(lw(8, 0), 0);
        apply(alu(0, 7, 10, 1), 0);
        chk("r0_nostall", 16'(pc_stall), 16'd0);
        tick();
        apply(bubble(), 0);
        chk("r0_fwd", 16'(fwd_a_sel), 16'd0);
        tick();

        // Flush beats a simultaneous load-use stall.
        step(lw(1, 8), 0);
        saved = int'(stall_count);
        apply(alu(8, 7, 9, 1), 1);
        chk("fl_flush", 16'(ifid_flush), 16'd1);
        chk("fl_bubble", 16'(idex_bubble), 16'd1);
        chk("fl_pc", 16'(pc_stall), 16'd0);
        tick();
        chk("fl_cnt", 16'(stall_count), 16'(saved));
        apply(bubble(), 0);
        chk("fl_ex_bubble", 16'(fwd_a_sel), 16'd0);
        tick();

        // mult followed by div: three stall cycles.
        step(bubble(), 0);
        saved = int'(stall_count);
        step(mdu(1, 2), 0);
        for (int k = 0; k < LAT - 1; k++) begin
            apply(mdu(3, 1), 0);
            chk("mdu_stall", 16'(pc_stall), 16'd1);
            chk("mdu_busy_on", 16'(mdu_busy), 16'd1);
            tick();
        end
        apply(mdu(3, 1), 0);
        chk("mdu_issue", 16'(pc_stall), 16'd0);
        tick();
        chk("mdu_cnt", 16'(stall_count), 16'(saved + LAT - 1));

        // Asynchronous reset while the MDU runs and EX holds the div.
        apply(mdu(1, 1), 1);
        chk("pre_rst_busy", 16'(mdu_busy), 16'd1);
        #2 reset = 1'b0;
        #1;
        all_zero("arst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        apply(mdu(1, 2), 0);
        chk("post_rst_mdu", 16'(pc_stall), 16'd0);
        tick();

        // Random instruction streams against the model (counter also saturates).
        for (int k = 0; k < 400; k++)
            step(rnd_instr(), ($urandom_range(0, 9) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
